// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive buffer.
// UART_RX_FIFO_KEEP_ERR_EN widens each entry with the parity/stop error tags.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int DEFAULT_DEPTH = 16;

`ifdef UART_RX_FIFO_KEEP_ERR_EN
    localparam int ENTRY_W = UART_DATA_W + 2;

    typedef struct packed {
        logic [UART_DATA_W-1:0] data;
        logic                   perr;
        logic                   serr;
    } entry_t;
`else
    localparam int ENTRY_W = UART_DATA_W;

    typedef struct packed {
        logic [UART_DATA_W-1:0] data;
    } entry_t;
`endif

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port,
// one asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    // NOTE: the array is deliberately left out of reset; validity is tracked by
    // the pointers and count, so resetting storage would only cost flops and fanout.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: frame-edge detection, circular FIFO
// control and FWFT read port. Optional macro: UART_RX_FIFO_KEEP_ERR_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] rxdata,
    input  logic                   valid_rx,
    input  logic                   parity_error,
    input  logic                   stop_error,
    input  logic                   rd_ready,
    input  logic                   clr_overrun,
    output logic                   rd_valid,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_perr,
    output logic                   rd_serr,
    output logic [AW:0]            count,
    output logic                   empty,
    output logic                   full,
    output logic                   overrun
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic          evt;
    logic          evt_q;
    logic          push_req;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    entry_t        wr_entry;
    entry_t        head;

    assign evt = valid_rx | parity_error | stop_error;

`ifdef UART_RX_FIFO_KEEP_ERR_EN
    assign push_req = evt & ~evt_q;
`else
    // Without error tagging, only frames flagged good are worth storing.
    assign push_req = evt & ~evt_q & valid_rx;
`endif

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign rd_valid = ~empty;
    assign pop      = rd_valid & rd_ready;
    assign wr_en    = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = rxdata;
`ifdef UART_RX_FIFO_KEEP_ERR_EN
        wr_entry.perr = parity_error;
        wr_entry.serr = stop_error;
`endif
    end

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // NOTE: every register here uses <= so all state updates see pre-edge values;
    // blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_q   <= 1'b1;  // a level already high at reset release must not count as a frame
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            evt_q <= evt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // NOTE: each output below is given a value on every path through the block,
    // so no latch is inferred.
    always_comb begin
        rd_data = '0;
        rd_perr = 1'b0;
        rd_serr = 1'b0;
        if (!empty) begin
            rd_data = head.data;
`ifdef UART_RX_FIFO_KEEP_ERR_EN
            rd_perr = head.perr;
            rd_serr = head.serr;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic against a queue-based model of the buffer.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rxdata = '0;
    logic       valid_rx = 1'b0;
    logic       parity_error = 1'b0;
    logic       stop_error = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_serr;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rxdata       (rxdata),
        .valid_rx     (valid_rx),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .rd_ready     (rd_ready),
        .clr_overrun  (clr_overrun),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_perr      (rd_perr),
        .rd_serr      (rd_serr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overrun      (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UART_RX_FIFO_KEEP_ERR_EN
    localparam bit KEEP_ERR = 1'b1;
`else
    localparam bit KEEP_ERR = 1'b0;
`endif

    // Model: queue of {data, perr, serr}, sticky overrun, previous event level.
    logic [9:0] mq[$];
    bit         m_ovr   = 1'b0;
    bit         m_evt_q = 1'b1;

    // Apply the buffering rules to the current inputs, then advance one clock.
    task automatic step();
        bit evt, rise, keep, pop;
        if (!rst) begin
            mq.delete();
            m_ovr   = 1'b0;
            m_evt_q = 1'b1;
        end else begin
            evt  = valid_rx | parity_error | stop_error;
            rise = evt && !m_evt_q;
            keep = KEEP_ERR ? rise : (rise && valid_rx);
            pop  = (mq.size() != 0) && rd_ready;
            if (pop) void'(mq.pop_front());
            if (clr_overrun) m_ovr = 1'b0;
            if (keep) begin
                if (mq.size() < DEPTH)
                    mq.push_back({rxdata, KEEP_ERR & parity_error, KEEP_ERR & stop_error});
                else
                    m_ovr = 1'b1;
            end
            m_evt_q = evt;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] model_head();
        return (mq.size() != 0) ? mq[0] : 10'h000;
    endfunction

    task automatic push_frame(input logic [7:0] b);
        rxdata = b; valid_rx = 1'b1; step();
        valid_rx = 1'b0; step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        n_checks += 6;
        if (count !== 5'd0)   begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        if ({rd_data, rd_perr, rd_serr} !== 10'h000) begin
            n_fail++; $display("FAIL reset_rd_bus got=%h exp=000", {rd_data, rd_perr, rd_serr});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        rxdata = 8'h6F; valid_rx = 1'b1;
        step();
        n_checks += 2;
        if (count !== 5'd1)    begin n_fail++; $display("FAIL single_latency_count got=%0d exp=1", count); end
        if (rd_data !== 8'h6F) begin n_fail++; $display("FAIL single_latency_data got=%h exp=6f", rd_data); end
        repeat (19) step();
        n_checks += 3;
        if (count !== 5'd1)       begin n_fail++; $display("FAIL single_held_count got=%0d exp=1", count); end
        if (rd_valid !== 1'b1)    begin n_fail++; $display("FAIL single_rd_valid got=%b exp=1", rd_valid); end
        if (count !== 5'(mq.size())) begin n_fail++; $display("FAIL single_model_count got=%0d exp=%0d", count, mq.size()); end
        valid_rx = 1'b0; step();
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        n_checks += 2;
        if (empty !== 1'b1)    begin n_fail++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL single_pop_data got=%h exp=00", rd_data); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < DEPTH; i++) push_frame(8'(i));
        push_frame(8'hAA);
        n_checks += 3;
        if (full !== 1'b1)     begin n_fail++; $display("FAIL fill_full got=%b exp=1", full); end
        if (overrun !== 1'b1)  begin n_fail++; $display("FAIL fill_overrun got=%b exp=1", overrun); end
        if (count !== 5'd16)   begin n_fail++; $display("FAIL fill_count got=%0d exp=16", count); end
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, rd_data, 8'(i)); end
            step();
        end
        rd_ready = 1'b0;
        n_checks += 2;
        if (empty !== 1'b1)   begin n_fail++; $display("FAIL fill_drained_empty got=%b exp=1", empty); end
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL fill_overrun_sticky got=%b exp=1", overrun); end
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL fill_clr_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] last;
        for (int i = 0; i < DEPTH; i++) push_frame(8'(8'h10 + i));
        rxdata = 8'h55; valid_rx = 1'b1; rd_ready = 1'b1;
        step();
        valid_rx = 1'b0; rd_ready = 1'b0;
        step();
        n_checks += 3;
        if (count !== 5'd16)  begin n_fail++; $display("FAIL fullpp_count got=%0d exp=16", count); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL fullpp_overrun got=%b exp=0", overrun); end
        if (rd_data !== 8'h11) begin n_fail++; $display("FAIL fullpp_head got=%h exp=11", rd_data); end
        rd_ready = 1'b1;
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rd_data !== model_head()[9:2]) begin
                n_fail++; $display("FAIL fullpp_order[%0d] got=%h exp=%h", i, rd_data, model_head()[9:2]);
            end
            last = rd_data;
            step();
        end
        rd_ready = 1'b0;
        n_checks++;
        if (last !== 8'h55) begin n_fail++; $display("FAIL fullpp_last got=%h exp=55", last); end
    endtask

    task automatic test_error_frame();
        rxdata = 8'hCC; stop_error = 1'b1; valid_rx = 1'b0;
        step();
        stop_error = 1'b0;
        step();
        n_checks++;
        if (KEEP_ERR) begin
            if ({count, rd_data, rd_perr, rd_serr} !== {5'd1, 8'hCC, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL err_frame_kept got=cnt%0d/%h/p%b/s%b exp=cnt1/cc/p0/s1",
                                   count, rd_data, rd_perr, rd_serr);
            end
        end else begin
            if (count !== 5'd0) begin n_fail++; $display("FAIL err_frame_dropped got=%0d exp=0", count); end
        end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL err_frame_overrun got=%b exp=0", overrun); end
        rd_ready = 1'b1; step(); step(); rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        push_frame(8'h31); push_frame(8'h32); push_frame(8'h33);
        rxdata = 8'h77; valid_rx = 1'b1; rd_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks += 2;
        if (count !== 5'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", count); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got=%b exp=1", empty); end
        step(); step();
        rd_ready = 1'b0;
        rst = 1'b1;
        repeat (5) step();
        n_checks++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL midrst_no_capture got=%0d exp=0", count); end
        valid_rx = 1'b0; step();
        valid_rx = 1'b1; step();
        n_checks += 2;
        if (count !== 5'd1)    begin n_fail++; $display("FAIL midrst_rearm_count got=%0d exp=1", count); end
        if (rd_data !== 8'h77) begin n_fail++; $display("FAIL midrst_rearm_data got=%h exp=77", rd_data); end
        valid_rx = 1'b0; rd_ready = 1'b1; step(); rd_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        for (int k = 0; k < 40; k++) begin
            b = 8'(8'h80 + k);
            rxdata = b; valid_rx = 1'b1; step();
            n_checks += 2;
            if (rd_data !== b) begin n_fail++; $display("FAIL wrap_data[%0d] got=%h exp=%h", k, rd_data, b); end
            if (count > 5'd1)  begin n_fail++; $display("FAIL wrap_count[%0d] got=%0d exp<=1", k, count); end
            valid_rx = 1'b0; rd_ready = 1'b1; step(); rd_ready = 1'b0;
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_end_empty got=%b exp=1", empty); end
    endtask

    task automatic test_random();
        int ready_pct;
        for (int c = 0; c < 600; c++) begin
            ready_pct = ((c / 100) % 2 == 0) ? 15 : 80;
            if (valid_rx | parity_error | stop_error) begin
                if ($urandom_range(99) < 50) begin
                    valid_rx = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
                end
            end else if ($urandom_range(99) < 45) begin
                rxdata = 8'($urandom);
                if ($urandom_range(99) < 70) begin
                    valid_rx = 1'b1;
                end else begin
                    parity_error = 1'($urandom);
                    stop_error   = ~parity_error | 1'($urandom);
                end
            end
            rd_ready    = ($urandom_range(99) < ready_pct);
            clr_overrun = ($urandom_range(99) < 3);
            step();
            n_checks++;
            if ({rd_valid, rd_data, rd_perr, rd_serr, count, full, empty, overrun} !==
                {mq.size() != 0, model_head(), 5'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_ovr}) begin
                n_fail++;
                $display("FAIL random[%0d] got=v%b d%h p%b s%b c%0d f%b e%b o%b exp=d%h p%b s%b c%0d o%b",
                         c, rd_valid, rd_data, rd_perr, rd_serr, count, full, empty, overrun,
                         model_head()[9:2], model_head()[1], model_head()[0], mq.size(), m_ovr);
            end
        end
        valid_rx = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
        rd_ready = 1'b0; clr_overrun = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fill_overrun();
        test_full_push_pop();
        test_error_frame();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer placed directly downstream of the UART receiver (UART_RX_TOP). Detects each completed frame on the receiver's result outputs, stores the byte (plus error tags when configured) in a circular FIFO, and presents it to the host side through a first-word-fall-through valid/ready port. Reports occupancy, full/empty and a sticky overrun flag.

## Interface
- DEPTH, 16, number of entries; power of two, 2..256
- AW, $clog2(DEPTH), pointer width (derived; not overridden)
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- RXDATA  in  8  received byte from receiver
- VALID_RX  in  1  receiver frame-good level
- PARITY_ERROR  in  1  receiver parity-error level
- STOP_ERROR  in  1  receiver stop-error level
- RD_READY  in  1  consumer accepts head entry this cycle
- CLR_OVERRUN  in  1  clears OVERRUN
- RD_VALID  out  1  head entry available (= !EMPTY)
- RD_DATA  out  8  head byte; 0 when empty
- RD_PERR  out  1  head entry parity-error tag (0 when macro off or empty)
- RD_SERR  out  1  head entry stop-error tag (0 when macro off or empty)
- COUNT  out  AW+1  entries stored, 0..DEPTH
- EMPTY  out  1  COUNT==0
- FULL  out  1  COUNT==DEPTH
- OVERRUN  out  1  sticky: a frame was dropped because FIFO was full

## Operation
- Frame event: rising edge of EVT = VALID_RX | PARITY_ERROR | STOP_ERROR, via one register EVT_Q; push = EVT & ~EVT_Q. Level held high for many cycles yields exactly one push.
- Good frame (VALID_RX=1, no error): entry {RXDATA, 0, 0} pushed.
- Errored frame: handling per macro (Configuration).
- Pop = RD_VALID & RD_READY; read pointer advances, COUNT decrements.
- Push accepted when !FULL, or when FULL and pop in same cycle (COUNT unchanged).
- Push when FULL without pop: entry dropped, pointers unchanged, OVERRUN set.
- Push and RD_READY while EMPTY: push only (no pop; RD_VALID was 0).
- OVERRUN: set by drop, cleared by CLR_OVERRUN; set wins if both same cycle.
- Pointers AW bits, wrap DEPTH-1 -> 0; COUNT tracked separately, AW+1 bits, never wraps.

## Timing
- Reset (RST=0, async): pointers 0, COUNT 0, EMPTY 1, FULL 0, OVERRUN 0, RD_VALID 0, RD_DATA/RD_PERR/RD_SERR 0, EVT_Q = 1. Storage array not reset.
- EVT_Q resets to 1: a level still high when reset releases is not captured; block arms only after EVT seen low. Reset mid-frame therefore discards the pending frame.
- Latency: input edge sampled at clock edge N; entry visible on RD_* and COUNT after edge N (i.e. in cycle N+1). Push-to-RD_VALID = 1 cycle.
- Pop: RD_DATA switches to next entry in the cycle after the accepting edge; combinational from registered pointer, no RD_READY-to-RD_DATA path.
- Back-to-back pushes limited only by receiver (one per frame); one push and one pop possible every cycle.
- RST asserted while RD_READY high: no pop; all state cleared immediately.

## Configuration
- UART_RX_FIFO_KEEP_ERR_EN defined: errored frames pushed as {RXDATA, PARITY_ERROR, STOP_ERROR}; entry width 10; RD_PERR/RD_SERR carry tags.
- Not defined: errored frames (event with VALID_RX=0) silently discarded, no push, no OVERRUN effect; entry width 8; RD_PERR/RD_SERR tied 0.

## Structure
- Package uart_pkg: UART_DATA_W = 8, entry width constant (8 or 10 per macro), entry typedef {data, perr, serr}, default DEPTH.
- Sub-module uart_fifo_mem: DEPTH x entry register array, one synchronous write port, one asynchronous read port; no reset. Control (edge detect, pointers, COUNT, flags) in uart_rx_fifo.

## Test plan
- Reset then single good frame: RXDATA=0x6F, VALID_RX held high 20 cycles -> exactly one entry, COUNT=1, RD_DATA=0x6F one cycle after edge; RD_READY=1 -> EMPTY=1, RD_DATA=0.
- Fill DEPTH=16 with 0x00..0x0F, one more frame 0xAA -> FULL=1, OVERRUN=1, 0xAA dropped; pops return 0x00..0x0F in order, CLR_OVERRUN -> OVERRUN=0.
- FULL plus simultaneous push 0x55 and pop -> COUNT stays 16, OVERRUN=0, 0x55 read last.
- Errored frame RXDATA=0xCC, STOP_ERROR=1, VALID_RX=0: macro on -> entry 0xCC, RD_SERR=1, RD_PERR=0; macro off -> COUNT stays 0.
- Reset asserted while VALID_RX high and 3 entries stored -> COUNT=0, EMPTY=1 immediately; after release with VALID_RX still high -> no push until VALID_RX drops and rises again.
- Pointer wrap: 40 push/pop pairs of incrementing bytes -> every byte read back in order, COUNT never exceeds 1.
